// File: rtl/wr_resp_route_arb.sv
// wr_resp_route_arb
// Routes write responses from IN_NUM bank-side channels to OUT_NUM master-side
// channels. The destination master is txnid[TXNID_WIDTH-1:SEL_LSB]. Each output
// has a round-robin arbiter over all inputs followed by a FIFO_DEPTH-entry
// response buffer.
//
// Optional feature macro: WR_RESP_ROUTE_ERR_CHK_EN
//   When defined, adds err_vld / err_txnid / err_clr. These record the txnid of
//   the first accepted response whose master id is out of range.
//   When undefined, such responses are accepted and dropped silently.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_vld/in_rdy      per-input response handshake
//   in_txnid, in_pld   per-input routing txnid and payload
//   out_vld/out_rdy    per-output response handshake
//   out_pld            per-output payload (head of that output's buffer)
//   err_vld, err_txnid sticky out-of-range capture (macro only)
//   err_clr            clears the capture, wins over a same-cycle capture (macro only)
//
// Handshake: a transfer happens on a rising clk edge where vld && rdy are both
// high. A producer holds vld and its data stable until the transfer happens.
// in_rdy is driven only from in_vld, in_txnid and registered state; out_rdy
// never reaches in_rdy combinationally.
module wr_resp_route_arb #(
    parameter int IN_NUM      = 8,
    parameter int OUT_NUM     = 8,
    parameter int PLD_WIDTH   = 32,
    parameter int TXNID_WIDTH = 8,
    parameter int SEL_LSB     = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [IN_NUM-1:0]                     in_vld,
    output logic [IN_NUM-1:0]                     in_rdy,
    input  logic [IN_NUM-1:0][TXNID_WIDTH-1:0]    in_txnid,
    input  logic [IN_NUM-1:0][PLD_WIDTH-1:0]      in_pld,
    output logic [OUT_NUM-1:0]                    out_vld,
    input  logic [OUT_NUM-1:0]                    out_rdy,
    output logic [OUT_NUM-1:0][PLD_WIDTH-1:0]     out_pld
`ifdef WR_RESP_ROUTE_ERR_CHK_EN
    ,
    output logic                                  err_vld,
    output logic [TXNID_WIDTH-1:0]                err_txnid,
    input  logic                                  err_clr
`endif
);

    localparam int IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int FP_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Registered state
    logic [OUT_NUM-1:0][IDX_W-1:0] rr_ptr;
    logic [OUT_NUM-1:0][FP_W-1:0]  wr_ptr;
    logic [OUT_NUM-1:0][FP_W-1:0]  rd_ptr;
    logic [OUT_NUM-1:0][CNT_W-1:0] count;
    logic [PLD_WIDTH-1:0]          mem [OUT_NUM][FIFO_DEPTH];

    // Combinational decode and arbitration
    logic [IN_NUM-1:0]              oor;
    logic [IN_NUM-1:0][OUT_NUM-1:0] req;
    logic [IN_NUM-1:0][OUT_NUM-1:0] gnt;
    logic [OUT_NUM-1:0]             gnt_any;
    logic [OUT_NUM-1:0][IDX_W-1:0]  gnt_idx;
    logic [OUT_NUM-1:0][PLD_WIDTH-1:0] win_pld;
    logic [OUT_NUM-1:0]             push;
    logic [OUT_NUM-1:0]             pop;

    // Request matrix: each input raises at most one request bit. An
    // out-of-range id raises none and is flagged for dropping instead.
    always_comb begin
        oor = '0;
        req = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (int'(in_txnid[i][TXNID_WIDTH-1:SEL_LSB]) >= OUT_NUM) begin
                oor[i] = in_vld[i];
            end else begin
                for (int j = 0; j < OUT_NUM; j++) begin
                    req[i][j] = in_vld[i] && (int'(in_txnid[i][TXNID_WIDTH-1:SEL_LSB]) == j);
                end
            end
        end
    end

    // Round-robin: the first requester at or after rr_ptr, scanning cyclically.
    // A full buffer (registered count) grants nobody.
    always_comb begin : arb_comb
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_any = '0;
        gnt_idx = '0;
        for (int j = 0; j < OUT_NUM; j++) begin
            if (count[j] < CNT_W'(FIFO_DEPTH)) begin
                for (int k = 0; k < IN_NUM; k++) begin
                    idx = (int'(rr_ptr[j]) + k) % IN_NUM;
                    if (!gnt_any[j] && req[idx][j]) begin
                        gnt_any[j]   = 1'b1;
                        gnt_idx[j]   = IDX_W'(idx);
                        gnt[idx][j]  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            in_rdy[i] = in_vld[i] && (oor[i] || (|gnt[i]));
        end
    end

    always_comb begin
        for (int j = 0; j < OUT_NUM; j++) begin
            win_pld[j] = in_pld[gnt_idx[j]];
            out_vld[j] = (count[j] != '0);
            out_pld[j] = mem[j][rd_ptr[j]];
            push[j]    = gnt_any[j];
            pop[j]     = out_vld[j] && out_rdy[j];
        end
    end

    // Pointers and counts. Pointers wrap explicitly so FIFO_DEPTH need not be
    // a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int j = 0; j < OUT_NUM; j++) begin
                if (gnt_any[j]) begin
                    rr_ptr[j] <= (gnt_idx[j] == IDX_W'(IN_NUM - 1)) ? '0 : gnt_idx[j] + 1'b1;
                end
                if (push[j]) begin
                    wr_ptr[j] <= (wr_ptr[j] == FP_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr[j] + 1'b1;
                end
                if (pop[j]) begin
                    rd_ptr[j] <= (rd_ptr[j] == FP_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr[j] + 1'b1;
                end
                if (push[j] && !pop[j]) begin
                    count[j] <= count[j] + 1'b1;
                end else if (!push[j] && pop[j]) begin
                    count[j] <= count[j] - 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset: out_vld masks stale entries.
    always_ff @(posedge clk) begin
        for (int j = 0; j < OUT_NUM; j++) begin
            if (push[j]) begin
                mem[j][wr_ptr[j]] <= win_pld[j];
            end
        end
    end

`ifdef WR_RESP_ROUTE_ERR_CHK_EN
    logic                   err_hit;
    logic [TXNID_WIDTH-1:0] err_pick;

    // Lowest-index out-of-range input supplies the captured txnid.
    always_comb begin
        err_hit  = 1'b0;
        err_pick = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            if (!err_hit && oor[i]) begin
                err_hit  = 1'b1;
                err_pick = in_txnid[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vld   <= 1'b0;
            err_txnid <= '0;
        end else if (err_clr) begin
            err_vld   <= 1'b0;
            err_txnid <= '0;
        end else if (!err_vld && err_hit) begin
            err_vld   <= 1'b1;
            err_txnid <= err_pick;
        end
    end
`endif

endmodule
